tone_i2s_tx: RTL and testbench

TONE_I2S_TX -- requirements
Module: tone_i2s_tx

---
 rtl/audio_pkg.sv | 34 +++
 rtl/counter.sv | 49 ++++
 rtl/tone_i2s_tx.sv | 115 +++++++++++
 tb/tb_tone_i2s_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg
// ----------------------------------------------------------------------------
// Shared widths and amplitude for the tone generator / I2S transmitter, plus
// the square-wave sample function used at every frame start.
// Revision: 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int DIV_W    = 9;
  localparam int SAMPLE_W = 24;
  localparam int FSTEP_W  = 32;

  localparam logic [SAMPLE_W-1:0] AMP_FULL = 24'h200000;

  // Square wave: sign from the phase MSB, amplitude attenuated by vol,
  // forced to zero when the step is zero (silence).
  function automatic logic [SAMPLE_W-1:0] waveform(
    input logic                phase_msb,
    input logic [FSTEP_W-1:0]  fstep,
    input logic [1:0]          vol
  );
    logic [SAMPLE_W-1:0] amp;
    amp = AMP_FULL >> vol;
    if (fstep == '0) begin
      return '0;
    end
    return phase_msb ? ('0 - amp) : amp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// counter
// ----------------------------------------------------------------------------
// Generic free-running up/down counter with synchronous active-high reset.
// Wraps naturally at the width boundary.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset (count -> 0)
//   up_i     - count up when set (and down_i clear)
//   down_i   - count down when set (and up_i clear)
//   count_o  - current count, straight from the register
// Revision: 1.0 - initial release
// ============================================================================
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = count_q + 1'b1;
    end else if (down_i && !up_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/tone_i2s_tx.sv
`default_nettype none
// ============================================================================
// tone_i2s_tx
// ----------------------------------------------------------------------------
// Square-wave tone generator driving an I2S DAC. A 9-bit divider defines a
// 512-cycle frame (two 32-slot channels); once per frame the phase
// accumulator advances and a new sample is latched, then serialised MSB
// first with the one-bit I2S delay, identical on left and right.
// Ports:
//   clk_i         - system clock
//   reset_i       - synchronous active-high reset
//   fstep_i       - phase step, sampled at frame start (0 = silence)
//   vol_i         - attenuation, sampled at frame start
//   mclk_o        - clk/2 master clock
//   sclk_o        - clk/8 bit clock
//   lrck_o        - clk/512 word select (0 = left)
//   sdata_o       - serial data, changes on sclk falling edges
//   sample_tick_o - one-cycle pulse in the frame-start cycle
// Revision: 1.0 - initial release
// ============================================================================
module tone_i2s_tx
  import audio_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [FSTEP_W-1:0] fstep_i,
  input  logic [1:0]         vol_i,
  output logic               mclk_o,
  output logic               sclk_o,
  output logic               lrck_o,
  output logic               sdata_o,
  output logic               sample_tick_o
);

  localparam logic [DIV_W-1:0] DIV_LAST  = '1;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(255);

  logic [DIV_W-1:0]    div_q;
  logic [FSTEP_W-1:0]  phase_q, phase_d;
  logic [FSTEP_W-1:0]  fstep_q, fstep_d;
  logic [1:0]          vol_q, vol_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [31:0]         sreg_q, sreg_d;
  logic                sdata_q, sdata_d;
  logic                tick_q, tick_d;

  counter #(
    .WIDTH (DIV_W)
  ) u_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (1'b1),
    .down_i  (1'b0),
    .count_o (div_q)
  );

  // All decisions look at the current divider value, i.e. they describe
  // what happens on the edge entering the next value.
  always_comb begin
    phase_d  = phase_q;
    fstep_d  = fstep_q;
    vol_d    = vol_q;
    sample_d = sample_q;
    sreg_d   = sreg_q;
    sdata_d  = sdata_q;
    // Registered so the pulse cannot appear in the first cycle out of reset,
    // which has div_q == 0 without a 511 -> 0 transition.
    tick_d   = (div_q == DIV_LAST);

    if (div_q == DIV_LAST) begin
      fstep_d  = fstep_i;
      vol_d    = vol_i;
      sample_d = waveform(phase_q[FSTEP_W-1], fstep_q, vol_q);
      phase_d  = (fstep_q == '0) ? '0 : phase_q + fstep_q;
      sreg_d   = {sample_d, 8'b0};
      sdata_d  = 1'b0;
    end else if (div_q == HALF_LAST) begin
      sreg_d   = {sample_q, 8'b0};
      sdata_d  = 1'b0;
    end else if (div_q[2:0] == 3'b111) begin
      // Entering a slot boundary = falling edge of sclk_o.
      sdata_d  = sreg_q[31];
      sreg_d   = {sreg_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q  <= '0;
      fstep_q  <= '0;
      vol_q    <= '0;
      sample_q <= '0;
      sreg_q   <= '0;
      sdata_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      fstep_q  <= fstep_d;
      vol_q    <= vol_d;
      sample_q <= sample_d;
      sreg_q   <= sreg_d;
      sdata_q  <= sdata_d;
      tick_q   <= tick_d;
    end
  end

  assign mclk_o        = div_q[0];
  assign sclk_o        = div_q[2];
  assign lrck_o        = div_q[8];
  assign sdata_o       = sdata_q;
  assign sample_tick_o = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_i2s_tx.sv
`default_nettype none
// ============================================================================
// tb_tone_i2s_tx
// ----------------------------------------------------------------------------
// Self-checking bench: a frame-level reference (phase as an unsigned number
// modulo 2^32, square wave from its half) predicts the sample of every frame;
// the serial stream is decoded per channel and compared, together with the
// clock outputs, the frame tick and the sdata timing rule.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tone_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] fstep_i = '0;
  logic [1:0]  vol_i = '0;
  logic        mclk_o, sclk_o, lrck_o, sdata_o, sample_tick_o;

  tone_i2s_tx dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .fstep_i       (fstep_i),
    .vol_i         (vol_i),
    .mclk_o        (mclk_o),
    .sclk_o        (sclk_o),
    .lrck_o        (lrck_o),
    .sdata_o       (sdata_o),
    .sample_tick_o (sample_tick_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: cycles since frame start, frames since reset.
  int          pos;
  int          nframes;
  longint      m_phase, m_fstep;
  int          m_vol;
  logic [23:0] m_sample;
  logic [31:0] wbuf;
  logic [31:0] left_word;
  logic        prev_sd;
  logic [23:0] dec_l[$];

  function automatic logic [23:0] ref_sample(longint ph, longint fs, int v);
    int amp;
    if (fs == 0) return 24'd0;
    amp = 'h200000 / (1 << v);
    if (ph < 64'h8000_0000) return 24'(amp);
    return 24'((1 << 24) - amp);
  endfunction

  task automatic check_outputs();
    logic [8:0]  p;
    logic [2:0]  exp_clk;
    logic        exp_tick;
    logic [31:0] exp_word;
    p = pos[8:0];
    exp_tick = (pos == 0) && (nframes > 0);
    exp_clk  = {p[0], p[2], p[8]};

    total++;
    if ($isunknown({mclk_o, sclk_o, lrck_o, sdata_o, sample_tick_o})) begin
      bad++;
      $display("FAIL xcheck pos=%0d got=%b%b%b%b%b required no X", pos,
               mclk_o, sclk_o, lrck_o, sdata_o, sample_tick_o);
    end
    total++;
    if (sample_tick_o !== exp_tick) begin
      bad++;
      $display("FAIL tick pos=%0d frame=%0d got=%b required=%b", pos, nframes,
               sample_tick_o, exp_tick);
    end
    total++;
    if ({mclk_o, sclk_o, lrck_o} !== exp_clk) begin
      bad++;
      $display("FAIL clocks pos=%0d got=%b required=%b", pos,
               {mclk_o, sclk_o, lrck_o}, exp_clk);
    end
    if (p[2:0] != 3'd0) begin
      total++;
      if (sdata_o !== prev_sd) begin
        bad++;
        $display("FAIL sdata_stable pos=%0d got=%b required=%b", pos, sdata_o, prev_sd);
      end
    end
    if (p[2:0] == 3'd4) wbuf = {wbuf[30:0], sdata_o};
    if (p[7:0] == 8'd255) begin
      exp_word = {1'b0, m_sample, 7'b0};
      total++;
      if (wbuf !== exp_word) begin
        bad++;
        $display("FAIL word frame=%0d ch=%0d got=%h required=%h", nframes,
                 p[8], wbuf, exp_word);
      end
      if (p[8] == 1'b0) begin
        left_word = wbuf;
        dec_l.push_back(wbuf[30:7]);
      end else begin
        total++;
        if (wbuf !== left_word) begin
          bad++;
          $display("FAIL l_eq_r frame=%0d got=%h required=%h", nframes, wbuf, left_word);
        end
      end
    end
    prev_sd = sdata_o;
  endtask

  // One clock; the reference applies the frame-start rules when a new frame
  // begins, using the inputs that were stable across that edge.
  task automatic step();
    @(negedge clk);
    pos = (pos + 1) % 512;
    if (pos == 0) begin
      nframes++;
      m_sample = ref_sample(m_phase, m_fstep, m_vol);
      m_phase  = (m_fstep == 0) ? 0 : (m_phase + m_fstep) % 64'h1_0000_0000;
      m_fstep  = longint'(fstep_i);
      m_vol    = int'(vol_i);
    end
    check_outputs();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic run_to(int p);
    for (int i = 0; i < 512 && pos != p; i++) step();
  endtask

  // Asserts reset at the current point (called at a falling edge).
  task automatic apply_reset(int hold);
    reset_i = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      total++;
      if ({mclk_o, sclk_o, lrck_o, sdata_o, sample_tick_o} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs got=%b required=00000",
                 {mclk_o, sclk_o, lrck_o, sdata_o, sample_tick_o});
      end
    end
    reset_i  = 1'b0;
    pos      = 0;
    nframes  = 0;
    m_phase  = 0;
    m_fstep  = 0;
    m_vol    = 0;
    m_sample = '0;
    wbuf     = '0;
    prev_sd  = 1'b0;
    dec_l.delete();
    check_outputs();
  endtask

  task automatic test_reset();
    fstep_i = '0;
    vol_i   = '0;
    apply_reset(3);
    run(3 * 512);
  endtask

  task automatic test_square();
    fstep_i = 32'h8000_0000;
    vol_i   = 2'd0;
    @(negedge clk);
    apply_reset(2);
    run(6 * 512);
    for (int f = 2; f < 6; f++) begin
      total++;
      if (dec_l[f] !== ((f % 2 == 0) ? 24'h200000 : 24'hE00000)) begin
        bad++;
        $display("FAIL square frame=%0d got=%h required=%h", f, dec_l[f],
                 (f % 2 == 0) ? 24'h200000 : 24'hE00000);
      end
    end
  endtask

  task automatic test_quarter();
    logic [23:0] exp_q[7];
    exp_q = '{24'h0, 24'h0, 24'h080000, 24'h080000, 24'hF80000, 24'hF80000, 24'h080000};
    fstep_i = 32'h4000_0000;
    vol_i   = 2'd2;
    @(negedge clk);
    apply_reset(2);
    run(7 * 512);
    for (int f = 0; f < 7; f++) begin
      total++;
      if (dec_l[f] !== exp_q[f]) begin
        bad++;
        $display("FAIL quarter frame=%0d got=%h required=%h", f, dec_l[f], exp_q[f]);
      end
    end
  endtask

  task automatic test_midframe_change();
    fstep_i = 32'h8000_0000;
    vol_i   = 2'd1;
    run(2 * 512);
    run_to(100);
    fstep_i = $urandom();
    vol_i   = 2'($urandom_range(0, 3));
    run(4 * 512);
  endtask

  task automatic test_wrap();
    fstep_i = 32'hFFFF_FFFF;
    vol_i   = 2'($urandom_range(0, 3));
    @(negedge clk);
    apply_reset(2);
    run(5 * 512);
    total++;
    if (dec_l[3] !== 24'((1 << 24) - ('h200000 >> vol_i))) begin
      bad++;
      $display("FAIL wrap frame=3 got=%h required=%h", dec_l[3],
               24'((1 << 24) - ('h200000 >> vol_i)));
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      // Inputs wiggled mid-frame; only the values present at the frame
      // start edge may matter.
      run_to(511);
      fstep_i = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
      vol_i   = 2'($urandom_range(0, 3));
      step();
      run_to($urandom_range(10, 500));
      fstep_i = $urandom();
      vol_i   = 2'($urandom_range(0, 3));
    end
    run(512);
  endtask

  task automatic test_reset_midword();
    fstep_i = 32'h8000_0000;
    vol_i   = 2'd0;
    run(2 * 512);
    run_to(300);
    apply_reset(1);
    run(2 * 512);
  endtask

  initial begin
    test_reset();
    test_square();
    test_quarter();
    test_midframe_change();
    test_wrap();
    test_random();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
